watch_time_cntr: RTL and testbench

WATCH_TIME_CNTR -- requirements
Module: watch_time_cntr

---
 rtl/watch_time_cntr.sv | 181 ++++++++++++++++++
 tb/tb_watch_time_cntr.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/watch_time_cntr.sv
// BCD hh:mm:ss watch counter with STOP/RUN/SET control.
// The 1 Hz wave and all buttons are asynchronous inputs, synchronized to clk.
module watch_time_cntr #(
  parameter int unsigned HOURS_PER_DAY = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clk_1Hz,
  input  logic       i_start_stop,
  input  logic       i_set,
  input  logic [1:0] i_sel,
  input  logic       i_inc,
  output logic [3:0] o_sec_ones,
  output logic [2:0] o_sec_tens,
  output logic [3:0] o_min_ones,
  output logic [2:0] o_min_tens,
  output logic [3:0] o_hr_ones,
  output logic [1:0] o_hr_tens,
  output logic [1:0] o_state,
  output logic       o_day_pulse
);

  localparam logic [1:0] HR_MAX_TENS = 2'((HOURS_PER_DAY - 1) / 10);
  localparam logic [3:0] HR_MAX_ONES = 4'((HOURS_PER_DAY - 1) % 10);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_SET  = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_sync1;      // {inc, set, start_stop, clk_1Hz}
  logic [3:0] r_sync2;
  logic [1:0] r_sel_s1;
  logic [1:0] r_sel_s2;
  logic [2:0] r_prev;       // {inc, start_stop, clk_1Hz}
  logic [1:0] r_arm_cnt;
  logic       r_tick;
  logic       r_ss_pulse;
  logic       r_inc_pulse;

  logic [3:0] r_sec_ones;
  logic [2:0] r_sec_tens;
  logic [3:0] r_min_ones;
  logic [2:0] r_min_tens;
  logic [3:0] r_hr_ones;
  logic [1:0] r_hr_tens;
  logic       r_day_pulse;

  logic       w_armed;
  logic       w_set_s;
  logic [2:0] w_rise;
  logic       w_run_tick;
  logic       w_set_inc;
  logic       w_sec_max;
  logic       w_min_max;
  logic       w_hr_max;
  logic [3:0] w_sec_ones_nxt;
  logic [2:0] w_sec_tens_nxt;
  logic [3:0] w_min_ones_nxt;
  logic [2:0] w_min_tens_nxt;
  logic [3:0] w_hr_ones_nxt;
  logic [1:0] w_hr_tens_nxt;

  // Edge detection stays disarmed until the synchronizer and previous-value
  // flops hold real input samples, so a level already high at reset release
  // never looks like a rising edge.
  assign w_armed = (r_arm_cnt == 2'd3);
  assign w_set_s = r_sync2[2];
  assign w_rise  = {r_sync2[3], r_sync2[1], r_sync2[0]} & ~r_prev & {3{w_armed}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1     <= '0;
      r_sync2     <= '0;
      r_sel_s1    <= '0;
      r_sel_s2    <= '0;
      r_prev      <= '0;
      r_arm_cnt   <= '0;
      r_tick      <= 1'b0;
      r_ss_pulse  <= 1'b0;
      r_inc_pulse <= 1'b0;
    end else begin
      r_sync1     <= {i_inc, i_set, i_start_stop, i_clk_1Hz};
      r_sync2     <= r_sync1;
      r_sel_s1    <= i_sel;
      r_sel_s2    <= r_sel_s1;
      r_prev      <= {r_sync2[3], r_sync2[1], r_sync2[0]};
      if (!w_armed) r_arm_cnt <= r_arm_cnt + 2'd1;
      r_tick      <= w_rise[0];
      r_ss_pulse  <= w_rise[1];
      r_inc_pulse <= w_rise[2];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_STOP;
    end else if (w_set_s) begin
      r_state <= ST_SET;
    end else begin
      case (r_state)
        ST_STOP: if (r_ss_pulse) r_state <= ST_RUN;
        ST_RUN:  if (r_ss_pulse) r_state <= ST_STOP;
        default: r_state <= ST_STOP;
      endcase
    end
  end

  assign w_sec_max = (r_sec_tens == 3'd5) && (r_sec_ones == 4'd9);
  assign w_min_max = (r_min_tens == 3'd5) && (r_min_ones == 4'd9);
  assign w_hr_max  = (r_hr_tens == HR_MAX_TENS) && (r_hr_ones == HR_MAX_ONES);

  assign w_sec_ones_nxt = (r_sec_ones == 4'd9) ? 4'd0 : r_sec_ones + 4'd1;
  assign w_sec_tens_nxt = (r_sec_ones != 4'd9) ? r_sec_tens :
                          (r_sec_tens == 3'd5) ? 3'd0 : r_sec_tens + 3'd1;
  assign w_min_ones_nxt = (r_min_ones == 4'd9) ? 4'd0 : r_min_ones + 4'd1;
  assign w_min_tens_nxt = (r_min_ones != 4'd9) ? r_min_tens :
                          (r_min_tens == 3'd5) ? 3'd0 : r_min_tens + 3'd1;
  assign w_hr_ones_nxt  = (w_hr_max || r_hr_ones == 4'd9) ? 4'd0 : r_hr_ones + 4'd1;
  assign w_hr_tens_nxt  = w_hr_max ? 2'd0 :
                          (r_hr_ones == 4'd9) ? r_hr_tens + 2'd1 : r_hr_tens;

  // Ticks only count while the state register already reads RUN; nothing is queued.
  assign w_run_tick = r_tick && (r_state == ST_RUN);
  assign w_set_inc  = r_inc_pulse && (r_state == ST_SET);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sec_ones  <= '0;
      r_sec_tens  <= '0;
      r_min_ones  <= '0;
      r_min_tens  <= '0;
      r_hr_ones   <= '0;
      r_hr_tens   <= '0;
      r_day_pulse <= 1'b0;
    end else begin
      r_day_pulse <= 1'b0;
      if (w_run_tick) begin
        r_sec_ones <= w_sec_ones_nxt;
        r_sec_tens <= w_sec_tens_nxt;
        if (w_sec_max) begin
          r_min_ones <= w_min_ones_nxt;
          r_min_tens <= w_min_tens_nxt;
          if (w_min_max) begin
            r_hr_ones <= w_hr_ones_nxt;
            r_hr_tens <= w_hr_tens_nxt;
            if (w_hr_max) r_day_pulse <= 1'b1;
          end
        end
      end else if (w_set_inc) begin
        case (r_sel_s2)
          2'd0: begin
            r_sec_ones <= '0;
            r_sec_tens <= '0;
          end
          2'd1: begin
            r_min_ones <= w_min_ones_nxt;
            r_min_tens <= w_min_tens_nxt;
          end
          2'd2: begin
            r_hr_ones <= w_hr_ones_nxt;
            r_hr_tens <= w_hr_tens_nxt;
          end
          default: ;
        endcase
      end
    end
  end

  assign o_sec_ones  = r_sec_ones;
  assign o_sec_tens  = r_sec_tens;
  assign o_min_ones  = r_min_ones;
  assign o_min_tens  = r_min_tens;
  assign o_hr_ones   = r_hr_ones;
  assign o_hr_tens   = r_hr_tens;
  assign o_state     = r_state;
  assign o_day_pulse = r_day_pulse;

endmodule

// File: tb/tb_watch_time_cntr.sv
// Directed bench for watch_time_cntr: a 24-hour and a 12-hour instance share stimulus.
module tb_watch_time_cntr;

  logic       clk;
  logic       reset;
  logic       i_clk_1Hz;
  logic       i_start_stop;
  logic       i_set;
  logic [1:0] i_sel;
  logic       i_inc;

  logic [3:0] a_sec_ones, b_sec_ones;
  logic [2:0] a_sec_tens, b_sec_tens;
  logic [3:0] a_min_ones, b_min_ones;
  logic [2:0] a_min_tens, b_min_tens;
  logic [3:0] a_hr_ones,  b_hr_ones;
  logic [1:0] a_hr_tens,  b_hr_tens;
  logic [1:0] a_state,    b_state;
  logic       a_day,      b_day;

  logic [19:0] time24, time12;
  assign time24 = {a_hr_tens, a_hr_ones, a_min_tens, a_min_ones, a_sec_tens, a_sec_ones};
  assign time12 = {b_hr_tens, b_hr_ones, b_min_tens, b_min_ones, b_sec_tens, b_sec_ones};

  int n_checks = 0;
  int n_pass   = 0;

  watch_time_cntr dut (
    .clk(clk), .reset(reset), .i_clk_1Hz(i_clk_1Hz), .i_start_stop(i_start_stop),
    .i_set(i_set), .i_sel(i_sel), .i_inc(i_inc),
    .o_sec_ones(a_sec_ones), .o_sec_tens(a_sec_tens), .o_min_ones(a_min_ones),
    .o_min_tens(a_min_tens), .o_hr_ones(a_hr_ones), .o_hr_tens(a_hr_tens),
    .o_state(a_state), .o_day_pulse(a_day)
  );

  watch_time_cntr #(.HOURS_PER_DAY(12)) dut12 (
    .clk(clk), .reset(reset), .i_clk_1Hz(i_clk_1Hz), .i_start_stop(i_start_stop),
    .i_set(i_set), .i_sel(i_sel), .i_inc(i_inc),
    .o_sec_ones(b_sec_ones), .o_sec_tens(b_sec_tens), .o_min_ones(b_min_ones),
    .o_min_tens(b_min_tens), .o_hr_ones(b_hr_ones), .o_hr_tens(b_hr_tens),
    .o_state(b_state), .o_day_pulse(b_day)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [19:0] t(input int h, input int m, input int s);
    return {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
  endfunction

  function automatic string ts(input logic [19:0] v);
    return $sformatf("%0d%0d:%0d%0d:%0d%0d", v[19:18], v[17:14], v[13:11], v[10:7], v[6:4], v[3:0]);
  endfunction

  function automatic bit digits_ok(input logic [19:0] v, input int hmax);
    return (v[3:0] <= 9) && (v[6:4] <= 5) && (v[10:7] <= 9) && (v[13:11] <= 5) &&
           (v[17:14] <= 9) && (int'(v[19:18]) * 10 + int'(v[17:14]) < hmax);
  endfunction

  // Inputs change 1 ns after a rising edge; outputs are read at the same point.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_1hz();
    i_clk_1Hz = 1'b1; cyc(3);
    i_clk_1Hz = 1'b0; cyc(3);
  endtask

  task automatic press_ss();
    i_start_stop = 1'b1; cyc(3);
    i_start_stop = 1'b0; cyc(3);
  endtask

  task automatic press_inc();
    i_inc = 1'b1; cyc(3);
    i_inc = 1'b0; cyc(3);
  endtask

  task automatic set_level(input logic v);
    i_set = v; cyc(4);
  endtask

  task automatic do_reset();
    reset = 1'b0; cyc(2);
    reset = 1'b1; cyc(4);
  endtask

  task automatic test_reset();
    cyc(3);
    n_checks++;
    if (time24 !== t(0, 0, 0)) $display("FAIL reset_time: got %s expected 00:00:00", ts(time24));
    else n_pass++;
    n_checks++;
    if (a_state !== 2'd0) $display("FAIL reset_state: got %0d expected 0", a_state);
    else n_pass++;
    n_checks++;
    if (a_day !== 1'b0) $display("FAIL reset_day_pulse: got %b expected 0", a_day);
    else n_pass++;
    reset = 1'b1;
    cyc(4);
  endtask

  task automatic test_run_tick();
    press_ss();
    n_checks++;
    if (a_state !== 2'd1) $display("FAIL run_state: got %0d expected 1", a_state);
    else n_pass++;
    i_clk_1Hz = 1'b1;
    cyc(3);
    n_checks++;
    if (time24 !== t(0, 0, 0)) $display("FAIL tick_early: got %s expected 00:00:00", ts(time24));
    else n_pass++;
    cyc(1);
    n_checks++;
    if (time24 !== t(0, 0, 1)) $display("FAIL tick_latency: got %s expected 00:00:01", ts(time24));
    else n_pass++;
    n_checks++;
    if (a_day !== 1'b0) $display("FAIL tick_day_pulse: got %b expected 0", a_day);
    else n_pass++;
    i_clk_1Hz = 1'b0;
    cyc(3);
  endtask

  task automatic test_set_mode();
    set_level(1'b1);
    n_checks++;
    if (a_state !== 2'd2) $display("FAIL set_state: got %0d expected 2", a_state);
    else n_pass++;
    i_sel = 2'd1;
    repeat (61) press_inc();
    n_checks++;
    if (time24 !== t(0, 1, 1)) $display("FAIL set_min61: got %s expected 00:01:01", ts(time24));
    else n_pass++;
    i_sel = 2'd0;
    press_inc();
    n_checks++;
    if (time24 !== t(0, 1, 0)) $display("FAIL set_sec_clear: got %s expected 00:01:00", ts(time24));
    else n_pass++;
    i_sel = 2'd3;
    press_inc();
    n_checks++;
    if (time24 !== t(0, 1, 0)) $display("FAIL set_sel3: got %s expected 00:01:00", ts(time24));
    else n_pass++;
    repeat (3) pulse_1hz();
    n_checks++;
    if (time24 !== t(0, 1, 0)) $display("FAIL set_tick_ignored: got %s expected 00:01:00", ts(time24));
    else n_pass++;
    i_sel = 2'd2;
    press_inc();
    n_checks++;
    if (time24 !== t(1, 1, 0)) $display("FAIL set_hour_inc: got %s expected 01:01:00", ts(time24));
    else n_pass++;
    set_level(1'b0);
    n_checks++;
    if (a_state !== 2'd0) $display("FAIL set_exit_state: got %0d expected 0", a_state);
    else n_pass++;
    press_ss();
    cyc(6);
    n_checks++;
    if (time24 !== t(1, 1, 0)) $display("FAIL no_queued_tick: got %s expected 01:01:00", ts(time24));
    else n_pass++;
    press_ss();
  endtask

  task automatic test_priority();
    i_set = 1'b1;
    i_start_stop = 1'b1;
    cyc(6);
    n_checks++;
    if (a_state !== 2'd2) $display("FAIL prio_set: got %0d expected 2", a_state);
    else n_pass++;
    i_start_stop = 1'b0;
    cyc(3);
    i_set = 1'b0;
    cyc(4);
    n_checks++;
    if (a_state !== 2'd0) $display("FAIL prio_exit: got %0d expected 0", a_state);
    else n_pass++;
    n_checks++;
    if (time24 !== t(1, 1, 0)) $display("FAIL prio_time: got %s expected 01:01:00", ts(time24));
    else n_pass++;
  endtask

  task automatic test_bcd_walk();
    int h = 0, m = 0, s = 0;
    int range_bad = 0, track_bad = 0;
    do_reset();
    press_ss();
    for (int k = 0; k < 600; k++) begin
      i_clk_1Hz = 1'b1;
      for (int c = 0; c < 6; c++) begin
        if (c == 3) i_clk_1Hz = 1'b0;
        cyc(1);
        if (!digits_ok(time24, 24) || !digits_ok(time12, 12)) range_bad++;
      end
      s++;
      if (s == 60) begin s = 0; m++; end
      if (m == 60) begin m = 0; h = (h + 1) % 24; end
      if (time24 !== t(h, m, s)) track_bad++;
    end
    n_checks++;
    if (range_bad !== 0) $display("FAIL walk_range: got %0d bad cycles expected 0", range_bad);
    else n_pass++;
    n_checks++;
    if (track_bad !== 0) $display("FAIL walk_track: got %0d wrong ticks expected 0", track_bad);
    else n_pass++;
    n_checks++;
    if (time24 !== t(0, 10, 0)) $display("FAIL walk_final: got %s expected 00:10:00", ts(time24));
    else n_pass++;
    press_ss();
  endtask

  task automatic test_rollover();
    do_reset();
    set_level(1'b1);
    i_sel = 2'd2;
    repeat (24) press_inc();
    n_checks++;
    if (time24 !== t(0, 0, 0)) $display("FAIL hr24_wrap: got %s expected 00:00:00", ts(time24));
    else n_pass++;
    n_checks++;
    if (time12 !== t(0, 0, 0)) $display("FAIL hr12_wrap: got %s expected 00:00:00", ts(time12));
    else n_pass++;
    repeat (23) press_inc();
    n_checks++;
    if (time24 !== t(23, 0, 0)) $display("FAIL hr24_set: got %s expected 23:00:00", ts(time24));
    else n_pass++;
    n_checks++;
    if (time12 !== t(11, 0, 0)) $display("FAIL hr12_set: got %s expected 11:00:00", ts(time12));
    else n_pass++;
    i_sel = 2'd1;
    repeat (59) press_inc();
    set_level(1'b0);
    press_ss();
    repeat (59) pulse_1hz();
    n_checks++;
    if (time24 !== t(23, 59, 59)) $display("FAIL pre_roll24: got %s expected 23:59:59", ts(time24));
    else n_pass++;
    n_checks++;
    if (time12 !== t(11, 59, 59)) $display("FAIL pre_roll12: got %s expected 11:59:59", ts(time12));
    else n_pass++;
    i_clk_1Hz = 1'b1;
    cyc(3);
    n_checks++;
    if (a_day !== 1'b0) $display("FAIL day_early: got %b expected 0", a_day);
    else n_pass++;
    cyc(1);
    n_checks++;
    if (time24 !== t(0, 0, 0)) $display("FAIL roll24: got %s expected 00:00:00", ts(time24));
    else n_pass++;
    n_checks++;
    if (time12 !== t(0, 0, 0)) $display("FAIL roll12: got %s expected 00:00:00", ts(time12));
    else n_pass++;
    n_checks++;
    if (a_day !== 1'b1) $display("FAIL day24_pulse: got %b expected 1", a_day);
    else n_pass++;
    n_checks++;
    if (b_day !== 1'b1) $display("FAIL day12_pulse: got %b expected 1", b_day);
    else n_pass++;
    cyc(1);
    n_checks++;
    if ({a_day, b_day} !== 2'b00) $display("FAIL day_width: got %b%b expected 00", a_day, b_day);
    else n_pass++;
    i_clk_1Hz = 1'b0;
    cyc(3);
    press_ss();
  endtask

  task automatic test_reset_midrun();
    do_reset();
    set_level(1'b1);
    i_sel = 2'd2;
    repeat (12) press_inc();
    i_sel = 2'd1;
    repeat (34) press_inc();
    set_level(1'b0);
    press_ss();
    repeat (56) pulse_1hz();
    n_checks++;
    if (time24 !== t(12, 34, 56) || a_state !== 2'd1)
      $display("FAIL midrun_pre: got %s state %0d expected 12:34:56 state 1", ts(time24), a_state);
    else n_pass++;
    #3;
    i_start_stop = 1'b1;
    i_inc = 1'b1;
    i_clk_1Hz = 1'b1;
    reset = 1'b0;
    #2;
    n_checks++;
    if (time24 !== t(0, 0, 0)) $display("FAIL async_reset_time: got %s expected 00:00:00", ts(time24));
    else n_pass++;
    n_checks++;
    if (a_state !== 2'd0) $display("FAIL async_reset_state: got %0d expected 0", a_state);
    else n_pass++;
    #11;
    reset = 1'b1;
    cyc(8);
    n_checks++;
    if (a_state !== 2'd0) $display("FAIL release_no_pulse_state: got %0d expected 0", a_state);
    else n_pass++;
    n_checks++;
    if (time24 !== t(0, 0, 0) || a_day !== 1'b0)
      $display("FAIL release_no_pulse_time: got %s day %b expected 00:00:00 day 0", ts(time24), a_day);
    else n_pass++;
    i_start_stop = 1'b0;
    i_inc = 1'b0;
    i_clk_1Hz = 1'b0;
    cyc(6);
  endtask

  initial begin
    reset = 1'b0;
    i_clk_1Hz = 1'b0;
    i_start_stop = 1'b0;
    i_set = 1'b0;
    i_sel = 2'd3;
    i_inc = 1'b0;
    test_reset();
    test_run_tick();
    test_set_mode();
    test_priority();
    test_bcd_walk();
    test_rollover();
    test_reset_midrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
